uniq_trk_sched: RTL and testbench
=================================

Name: uniq_trk_sched

Overview:
- Scheduler sharing one uniqueness-tracker datapath between N_REQ requesters.
- The tracker has a 4-deep, most-recent-first list of unique values, one input word per clock, synchronous clear.
- Round-robin arbitration of valid/ready requesters onto the tracker input, with idle-cycle hold.
- Controls the tracker clear (reset, flush, empty-hold) and returns a per-item response tag after the tracker pipeline latency.

Parameters:
- DATA_W, 8, width of data words.
- N_REQ, 4, number of requesters (≥2).
- TRK_LAT, 2, tracker input-to-out_0 latency in cycles.
- FLUSH_CYCLES, 2, cycles trk_reset is held during a flush (≥1).

Ports:
- clk_in  in  1  clock.
- reset_in  in  1  asynchronous active-high reset.
- req_valid  in  N_REQ  per-requester valid.
- req_data  in  N_REQ*DATA_W  packed requester words, requester i at bits [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  per-requester grant/ready (one-hot or zero).
- flush_in  in  1  single-cycle request to clear the tracker.
- flush_busy  out  1  high while in FLUSH.
- trk_reset  out  1  registered clear to the tracker's reset input.
- trk_data  out  DATA_W  registered word to the tracker's data input.
- rsp_valid  out  1  response strobe.
- rsp_id  out  $clog2(N_REQ)  requester index of the response.
- rsp_data  out  DATA_W  word of the response.

Behaviour:
- Reset values (reset_in high, asynchronous):
  - state=EMPTY, trk_reset=1, trk_data=0.
  - rr_ptr=N_REQ-1, so requester 0 has first priority.
  - rsp pipeline cleared; rsp_valid=0, rsp_id=0, rsp_data=0.
  - flush_busy=0.
- States:
  - EMPTY: tracker held clear; accepts requests.
  - RUN: accepts requests.
  - FLUSH: req_ready all 0; count down FLUSH_CYCLES.
- Grant conditions: a grant is possible only when state≠FLUSH and flush_in=0.
  - Winner = first i with req_valid[i]=1, searching from rr_ptr+1 with modulo N_REQ wrap.
  - req_ready[winner]=1 combinationally. Requesters must not make valid depend on ready.
- Handshake in cycle t (valid&ready):
  - trk_data<=req_data[winner] at the end of t.
  - rr_ptr<=winner.
  - The tagged entry {winner, data} enters a delay line.
- No handshake in RUN: trk_data holds its last value.
  - Re-presenting the most recent word is idempotent on the tracker: it matches entry 0, no shift occurs, and no new valid entry is added.
- EMPTY:
  - trk_reset stays 1 with no handshake. The tracker would otherwise latch stale trk_data as a new unique value.
  - First handshake: registers trk_data and trk_reset<=0 on the same edge; state<=RUN.
- RUN: trk_reset=0. flush_in=1 → FLUSH.
- FLUSH entry (from any state on flush_in=1):
  - trk_reset<=1, counter<=FLUSH_CYCLES-1.
  - Delay line cleared, so responses still in flight are discarded.
  - flush_busy<=1.
- FLUSH countdown: decrement each cycle; at 0 go to EMPTY, flush_busy<=0.
  - flush_in during FLUSH reloads the counter.
- flush_in together with a valid request: flush wins and no grant is issued.
- Response timing: rsp_valid pulses exactly TRK_LAT+1 cycles after the handshake cycle, with rsp_id=winner and rsp_data=word.
  - This aligns with the word appearing on the tracker's out_0 when it is unique.
  - rsp_id/rsp_data hold their last values when rsp_valid=0.
- Throughput is one grant per cycle. A requester held valid is granted at least once every N_REQ cycles.
- The delay line is TRK_LAT+1 stages of {valid, id, data}.

Optional Feature:
- Macro: UNIQ_TRK_SCHED_FIXED_PRIO_EN.
  - Defined: fixed priority, where the lowest index wins. rr_ptr is removed and starvation is permitted.
  - Undefined: round-robin as specified above.

Test Plan:
- Reset, then req_valid=0001 with words 1,2,1: grants in cycles t, t+1, t+2.
  - trk_reset falls on the edge that registers word 1.
  - rsp_valid at t+3, t+4, t+5 with id=0 and data 1,2,1.
- All four requesters valid continuously (words 10,11,12,13): req_ready sequence 0001,0010,0100,1000,0001.
  - rsp_id sequence 0,1,2,3,0.
- Requester 2 sends 7 once, then idle 5 cycles: trk_data stays 7 and trk_reset stays 0.
  - Exactly one rsp_valid pulse.
- flush_in at the handshake cycle of a request, with one item in flight:
  - No grant that cycle; the in-flight response is suppressed.
  - flush_busy high for 2 cycles, then EMPTY with trk_reset=1 until the next grant.
- flush_in repeated on the 2nd FLUSH cycle: FLUSH lasts 3 cycles total.
- Macro defined, req_valid=1010 continuously: requester 1 is granted every cycle and requester 3 never.

Source files
------------

// File: rtl/uniq_trk_sched.sv
// Scheduler that time-shares one 4-deep uniqueness tracker between N_REQ valid/ready requesters.
// Optional macro UNIQ_TRK_SCHED_FIXED_PRIO_EN selects lowest-index-wins priority instead of round-robin.
module uniq_trk_sched #(
    parameter int DATA_W       = 8,
    parameter int N_REQ        = 4,
    parameter int TRK_LAT      = 2,
    parameter int FLUSH_CYCLES = 2,
    localparam int ID_W        = $clog2(N_REQ)
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    flush_in,
    output logic                    flush_busy,
    output logic                    trk_reset,
    output logic [DATA_W-1:0]       trk_data,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [DATA_W-1:0]       rsp_data
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {EMPTY, RUN, FLUSH} state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  words [N_REQ];
    logic               handshake;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    cand;
    logic [DATA_W-1:0]  sel_data;
    int                 base;

    logic               dl_valid [TRK_LAT+1];
    logic [ID_W-1:0]    dl_id    [TRK_LAT+1];
    logic [DATA_W-1:0]  dl_data  [TRK_LAT+1];

`ifndef UNIQ_TRK_SCHED_FIXED_PRIO_EN
    logic [ID_W-1:0]    rr_ptr;
`endif

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            words[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Search starts just past the last winner so a held request is served within N_REQ grants.
    always_comb begin
        req_ready = '0;
        handshake = 1'b0;
        winner    = '0;
        cand      = '0;
        sel_data  = '0;
`ifdef UNIQ_TRK_SCHED_FIXED_PRIO_EN
        base      = 0;
`else
        base      = int'(rr_ptr) + 1;
`endif
        if (state != FLUSH && !flush_in) begin
            for (int k = 0; k < N_REQ; k++) begin
                cand = ID_W'((base + k) % N_REQ);
                if (!handshake && req_valid[cand]) begin
                    handshake = 1'b1;
                    winner    = cand;
                end
            end
            if (handshake) begin
                req_ready[winner] = 1'b1;
                sel_data          = words[winner];
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (flush_in) begin
            next_state = FLUSH;
        end else begin
            case (state)
                EMPTY:   if (handshake) next_state = RUN;
                RUN:     next_state = RUN;
                FLUSH:   if (cnt == '0) next_state = EMPTY;
                default: next_state = EMPTY;
            endcase
        end
    end

    // Tracker stays in clear until a real word arrives, so stale trk_data is never latched.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            trk_reset  <= 1'b1;
            trk_data   <= '0;
            cnt        <= '0;
            flush_busy <= 1'b0;
        end else if (flush_in) begin
            trk_reset  <= 1'b1;
            cnt        <= CNT_W'(FLUSH_CYCLES - 1);
            flush_busy <= 1'b1;
        end else begin
            if (state == FLUSH) begin
                if (cnt == '0) begin
                    flush_busy <= 1'b0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
            if (handshake) begin
                trk_data  <= sel_data;
                trk_reset <= 1'b0;
            end
        end
    end

`ifndef UNIQ_TRK_SCHED_FIXED_PRIO_EN
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            rr_ptr <= ID_W'(N_REQ - 1);
        end else if (handshake) begin
            rr_ptr <= winner;
        end
    end
`endif

    // The last stage doubles as the response register; tag and word only move with a valid entry.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int s = 0; s <= TRK_LAT; s++) begin
                dl_valid[s] <= 1'b0;
                dl_id[s]    <= '0;
                dl_data[s]  <= '0;
            end
        end else if (flush_in) begin
            for (int s = 0; s <= TRK_LAT; s++) begin
                dl_valid[s] <= 1'b0;
            end
        end else begin
            dl_valid[0] <= handshake;
            if (handshake) begin
                dl_id[0]   <= winner;
                dl_data[0] <= sel_data;
            end
            for (int s = 1; s <= TRK_LAT; s++) begin
                dl_valid[s] <= dl_valid[s-1];
                if (dl_valid[s-1]) begin
                    dl_id[s]   <= dl_id[s-1];
                    dl_data[s] <= dl_data[s-1];
                end
            end
        end
    end

    assign rsp_valid = dl_valid[TRK_LAT];
    assign rsp_id    = dl_id[TRK_LAT];
    assign rsp_data  = dl_data[TRK_LAT];

endmodule

// File: tb/tb_uniq_trk_sched.sv
// Self-checking bench for uniq_trk_sched: directed scenarios plus randomized traffic against a
// timestamped-queue reference model. Honours UNIQ_TRK_SCHED_FIXED_PRIO_EN like the design.
module tb_uniq_trk_sched;

    localparam int DATA_W       = 8;
    localparam int N_REQ        = 4;
    localparam int TRK_LAT      = 2;
    localparam int FLUSH_CYCLES = 2;
    localparam int ID_W         = $clog2(N_REQ);
    localparam int VW           = N_REQ + 2*DATA_W + ID_W + 3;
    localparam int PH_EMPTY     = 0;
    localparam int PH_RUN       = 1;
    localparam int PH_FLUSH     = 2;

    logic                    clk_in = 1'b0;
    logic                    reset_in = 1'b1;
    logic [N_REQ-1:0]        req_valid = '0;
    logic [N_REQ*DATA_W-1:0] req_data = '0;
    logic [N_REQ-1:0]        req_ready;
    logic                    flush_in = 1'b0;
    logic                    flush_busy;
    logic                    trk_reset;
    logic [DATA_W-1:0]       trk_data;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [DATA_W-1:0]       rsp_data;

    always #5 clk_in = ~clk_in;

    uniq_trk_sched #(
        .DATA_W(DATA_W), .N_REQ(N_REQ), .TRK_LAT(TRK_LAT), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk_in(clk_in), .reset_in(reset_in), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .flush_in(flush_in), .flush_busy(flush_busy),
        .trk_reset(trk_reset), .trk_data(trk_data), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    typedef struct {
        int                due;
        int                id;
        logic [DATA_W-1:0] data;
    } rsp_t;

    int                n_checks = 0;
    int                n_fail = 0;
    int                cyc = 0;
    rsp_t              m_q[$];
    int                m_phase, m_last, m_left, m_rsp_id;
    logic              m_trk_reset, m_busy;
    logic [DATA_W-1:0] m_trk_data, m_rsp_data;

    logic [VW-1:0]     obs_vec, exp_vec;
    logic [N_REQ-1:0]  obs_ready;
    logic              obs_trk_reset, obs_rsp_valid, obs_busy;
    logic [DATA_W-1:0] obs_trk_data, obs_rsp_data;
    logic [ID_W-1:0]   obs_rsp_id;

    task automatic model_init();
        m_q.delete();
        m_phase     = PH_EMPTY;
        m_last      = N_REQ - 1;
        m_left      = 0;
        m_trk_reset = 1'b1;
        m_trk_data  = '0;
        m_busy      = 1'b0;
        m_rsp_id    = 0;
        m_rsp_data  = '0;
    endtask

    task automatic apply_reset();
        @(posedge clk_in); #1;
        reset_in  = 1'b1;
        req_valid = '0;
        req_data  = '0;
        flush_in  = 1'b0;
        model_init();
        @(posedge clk_in); #1;
        reset_in = 1'b0;
    endtask

    // Drives one cycle, samples the DUT mid-cycle and advances the reference model across the edge.
    task automatic drive_cycle(input logic [N_REQ-1:0] v, input logic [N_REQ*DATA_W-1:0] d,
                               input logic f);
        int               w;
        int               i;
        logic [N_REQ-1:0] e_ready;
        logic             e_rsp;
        @(posedge clk_in); #1;
        req_valid = v;
        req_data  = d;
        flush_in  = f;
        #3;
        obs_ready     = req_ready;
        obs_trk_reset = trk_reset;
        obs_trk_data  = trk_data;
        obs_rsp_valid = rsp_valid;
        obs_rsp_id    = rsp_id;
        obs_rsp_data  = rsp_data;
        obs_busy      = flush_busy;
        obs_vec = {req_ready, trk_reset, trk_data, rsp_valid, rsp_id, rsp_data, flush_busy};

        w = -1;
        e_ready = '0;
        if (m_phase != PH_FLUSH && !f) begin
            for (int k = 0; k < N_REQ; k++) begin
`ifdef UNIQ_TRK_SCHED_FIXED_PRIO_EN
                i = k;
`else
                i = (m_last + 1 + k) % N_REQ;
`endif
                if (w < 0 && v[i]) w = i;
            end
        end
        if (w >= 0) e_ready[w] = 1'b1;
        e_rsp = 1'b0;
        if (m_q.size() > 0 && m_q[0].due == cyc) begin
            e_rsp      = 1'b1;
            m_rsp_id   = m_q[0].id;
            m_rsp_data = m_q[0].data;
            void'(m_q.pop_front());
        end
        exp_vec = {e_ready, m_trk_reset, m_trk_data, e_rsp, ID_W'(m_rsp_id), m_rsp_data, m_busy};

        if (f) begin
            m_phase     = PH_FLUSH;
            m_left      = FLUSH_CYCLES - 1;
            m_trk_reset = 1'b1;
            m_busy      = 1'b1;
            m_q.delete();
        end else begin
            if (m_phase == PH_FLUSH) begin
                if (m_left == 0) begin
                    m_phase = PH_EMPTY;
                    m_busy  = 1'b0;
                end else begin
                    m_left--;
                end
            end
            if (w >= 0) begin
                m_trk_data  = d[w*DATA_W +: DATA_W];
                m_trk_reset = 1'b0;
                m_phase     = PH_RUN;
                m_last      = w;
                m_q.push_back('{due: cyc + TRK_LAT + 1, id: w, data: d[w*DATA_W +: DATA_W]});
            end
        end
        cyc++;
    endtask

    task automatic test_reset();
        @(posedge clk_in); #1;
        reset_in  = 1'b1;
        req_valid = '1;
        req_data  = {8'd4, 8'd3, 8'd2, 8'd1};
        flush_in  = 1'b0;
        @(posedge clk_in); #2;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL reset_ready got=%b want=0001", req_ready);
        end
        n_checks++;
        if (trk_reset !== 1'b1 || trk_data !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_trk got=%b/%h want=1/00", trk_reset, trk_data);
        end
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_rsp got=%b/%0d/%h want=0/0/00", rsp_valid, rsp_id, rsp_data);
        end
        n_checks++;
        if (flush_busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_busy got=%b want=0", flush_busy);
        end
        req_valid = '0;
        model_init();
        @(posedge clk_in); #1;
        reset_in = 1'b0;
    endtask

    task automatic test_single_requester();
        logic [DATA_W-1:0]       seq [3] = '{8'd1, 8'd2, 8'd1};
        logic [N_REQ*DATA_W-1:0] d;
        apply_reset();
        for (int j = 0; j < 8; j++) begin
            d = '0;
            if (j < 3) begin
                d[DATA_W-1:0] = seq[j];
                drive_cycle(4'b0001, d, 1'b0);
            end else begin
                drive_cycle(4'b0000, d, 1'b0);
            end
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL single_model j=%0d got=%h want=%h", j, obs_vec, exp_vec);
            end
            if (j < 3) begin
                n_checks++;
                if (obs_ready !== 4'b0001) begin
                    n_fail++;
                    $display("[TB] FAIL single_ready j=%0d got=%b want=0001", j, obs_ready);
                end
            end
            if (j == 1) begin
                n_checks++;
                if (obs_trk_reset !== 1'b0 || obs_trk_data !== 8'd1) begin
                    n_fail++;
                    $display("[TB] FAIL single_trk j=1 got=%b/%h want=0/01", obs_trk_reset, obs_trk_data);
                end
            end
            if (j >= 3 && j <= 5) begin
                n_checks++;
                if (obs_rsp_valid !== 1'b1 || obs_rsp_id !== 2'd0 || obs_rsp_data !== seq[j-3]) begin
                    n_fail++;
                    $display("[TB] FAIL single_rsp j=%0d got=%b/%0d/%h want=1/0/%h",
                             j, obs_rsp_valid, obs_rsp_id, obs_rsp_data, seq[j-3]);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [N_REQ-1:0]  want_ready [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int                want_id [5] = '{0, 1, 2, 3, 0};
        logic [DATA_W-1:0] want_data [5] = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd10};
        int                ids[$];
        logic [DATA_W-1:0] datas[$];
        apply_reset();
        for (int j = 0; j < 9; j++) begin
            drive_cycle((j < 5) ? 4'b1111 : 4'b0000, {8'd13, 8'd12, 8'd11, 8'd10}, 1'b0);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL rr_model j=%0d got=%h want=%h", j, obs_vec, exp_vec);
            end
            if (j < 5) begin
                n_checks++;
                if (obs_ready !== want_ready[j]) begin
                    n_fail++;
                    $display("[TB] FAIL rr_ready j=%0d got=%b want=%b", j, obs_ready, want_ready[j]);
                end
            end
            if (obs_rsp_valid === 1'b1) begin
                ids.push_back(int'(obs_rsp_id));
                datas.push_back(obs_rsp_data);
            end
        end
        n_checks++;
        if (ids.size() != 5) begin
            n_fail++;
            $display("[TB] FAIL rr_rsp_count got=%0d want=5", ids.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if (ids[k] != want_id[k] || datas[k] !== want_data[k]) begin
                    n_fail++;
                    $display("[TB] FAIL rr_rsp k=%0d got=%0d/%h want=%0d/%h",
                             k, ids[k], datas[k], want_id[k], want_data[k]);
                end
            end
        end
    endtask

    task automatic test_fixed_prio();
        logic [N_REQ-1:0] seen;
        apply_reset();
        seen = '0;
        for (int j = 0; j < 8; j++) begin
            drive_cycle(4'b1010, {8'd33, 8'd22, 8'd11, 8'd0}, 1'b0);
            seen = seen | obs_ready;
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL fixed_model j=%0d got=%h want=%h", j, obs_vec, exp_vec);
            end
            n_checks++;
            if (obs_ready !== 4'b0010) begin
                n_fail++;
                $display("[TB] FAIL fixed_ready j=%0d got=%b want=0010", j, obs_ready);
            end
        end
        n_checks++;
        if (seen[3] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL fixed_starve got=%b want=0", seen[3]);
        end
    endtask

    task automatic test_idle_hold();
        logic [N_REQ*DATA_W-1:0] d;
        int                      pulses;
        pulses = 0;
        d = '0;
        d[2*DATA_W +: DATA_W] = 8'd7;
        for (int j = 0; j < 6; j++) begin
            drive_cycle((j == 0) ? 4'b0100 : 4'b0000, d, 1'b0);
            if (obs_rsp_valid === 1'b1) pulses++;
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL idle_model j=%0d got=%h want=%h", j, obs_vec, exp_vec);
            end
            if (j >= 1) begin
                n_checks++;
                if (obs_trk_data !== 8'd7 || obs_trk_reset !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL idle_hold j=%0d got=%h/%b want=07/0", j, obs_trk_data, obs_trk_reset);
                end
            end
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("[TB] FAIL idle_pulses got=%0d want=1", pulses);
        end
    endtask

    task automatic test_flush_inflight();
        logic [N_REQ*DATA_W-1:0] d;
        int                      busy_cnt, pulses;
        busy_cnt = 0;
        pulses   = 0;
        apply_reset();
        for (int j = 0; j < 13; j++) begin
            d = '0;
            if (j == 0) begin
                d[DATA_W +: DATA_W] = 8'h55;
                drive_cycle(4'b0010, d, 1'b0);
            end else if (j == 1) begin
                d[DATA_W +: DATA_W] = 8'h66;
                drive_cycle(4'b0010, d, 1'b1);
            end else if (j == 8) begin
                d[DATA_W-1:0] = 8'h21;
                drive_cycle(4'b0001, d, 1'b0);
            end else begin
                drive_cycle(4'b0000, d, 1'b0);
            end
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL flush_model j=%0d got=%h want=%h", j, obs_vec, exp_vec);
            end
            if (j == 1) begin
                n_checks++;
                if (obs_ready !== 4'b0000) begin
                    n_fail++;
                    $display("[TB] FAIL flush_nogrant got=%b want=0000", obs_ready);
                end
            end
            if (j >= 1 && j <= 7) begin
                if (obs_busy === 1'b1) busy_cnt++;
                if (obs_rsp_valid === 1'b1) pulses++;
            end
            if (j >= 2 && j <= 8) begin
                n_checks++;
                if (obs_trk_reset !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL flush_trk_reset j=%0d got=%b want=1", j, obs_trk_reset);
                end
            end
            if (j == 9) begin
                n_checks++;
                if (obs_trk_reset !== 1'b0 || obs_trk_data !== 8'h21) begin
                    n_fail++;
                    $display("[TB] FAIL flush_regrant got=%b/%h want=0/21", obs_trk_reset, obs_trk_data);
                end
            end
        end
        n_checks++;
        if (busy_cnt != 2) begin
            n_fail++;
            $display("[TB] FAIL flush_busy_len got=%0d want=2", busy_cnt);
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("[TB] FAIL flush_suppress got=%0d want=0", pulses);
        end
    endtask

    task automatic test_flush_repeat();
        int busy_cnt;
        busy_cnt = 0;
        for (int j = 0; j < 7; j++) begin
            drive_cycle(4'b0000, '0, (j < 2) ? 1'b1 : 1'b0);
            if (obs_busy === 1'b1) busy_cnt++;
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL refl_model j=%0d got=%h want=%h", j, obs_vec, exp_vec);
            end
        end
        n_checks++;
        if (busy_cnt != 3) begin
            n_fail++;
            $display("[TB] FAIL refl_busy_len got=%0d want=3", busy_cnt);
        end
    endtask

    task automatic test_random();
        logic [N_REQ*DATA_W-1:0] d;
        logic [N_REQ-1:0]        v;
        logic                    f;
        apply_reset();
        for (int j = 0; j < 300; j++) begin
            v = N_REQ'($urandom_range(0, (1 << N_REQ) - 1));
            d = N_REQ*DATA_W'($urandom);
            f = ($urandom_range(0, 15) == 0);
            drive_cycle(v, d, f);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("[TB] FAIL rand_model j=%0d got=%h want=%h", j, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        model_init();
        test_reset();
        test_single_requester();
`ifdef UNIQ_TRK_SCHED_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_round_robin();
`endif
        test_idle_hold();
        test_flush_inflight();
        test_flush_repeat();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
